stk_cmd_arb: RTL and testbench
==============================

# stk_cmd_arb

Round-robin arbiter that shares a single stack engine command port among `ENGS_N` requesters. It sits between the per-engine command interfaces (opcode, data, ack) and the stack datapath. It forwards one command per cycle and tracks which requester issued each outstanding POP in an in-order tag FIFO. It steers each stack response back to its owner as a one-hot valid with shared data.

## Interface
- `ENGS_N`, default `cfg_pkg::ENGS_N` (4): number of requesters.
- `W`, default 128: command/response data width.
- `TAG_DEPTH`, default 4: maximum outstanding POPs, power of two.

Ports:
- `clk`  in  1  clock.
- `arst_n`  in  1  reset, asynchronous and active-low.
- `i_cmd_opcode`  in  `ENGS_N` x `stk_pkg::opcode_t`  per-requester opcode. `OP_NOP` means idle.
- `i_cmd_dat`  in  `ENGS_N` x `W`  per-requester data; meaningful for `OP_PUSH` only.
- `o_cmd_ack`  out  `ENGS_N`  one-hot; command accepted this cycle.
- `o_stk_vld`  out  1  command valid to stack.
- `o_stk_opcode`  out  `opcode_t`  forwarded opcode.
- `o_stk_dat`  out  `W`  forwarded data.
- `i_stk_rdy`  in  1  stack accepts command.
- `i_stk_rsp_vld`  in  1  stack POP response valid, in issue order.
- `i_stk_rsp_dat`  in  `W`  stack POP response data.
- `o_rsp_vld`  out  `ENGS_N`  one-hot response to owning requester.
- `o_rsp_dat`  out  `W`  response data, shared by all requesters.
- `o_err`  out  1  sticky: a response arrived with no outstanding tag.

## Operation
- **Request:** requester r is requesting when `i_cmd_opcode[r] != OP_NOP`. It holds opcode and data stable until `o_cmd_ack[r]`.
- **Eligibility:** a request is eligible unless it is `OP_POP` and the tag FIFO is full. The full check uses registered occupancy. A same-cycle response does not free a slot for a same-cycle grant.
- **Winner:** the first eligible requester searching upward from `rr_ptr`, wrapping modulo `ENGS_N`.
- **Forwarding:** `o_stk_vld` = any eligible request. `o_stk_opcode`/`o_stk_dat` come from the winner. When `o_stk_vld` is 0, `o_stk_opcode` = `OP_NOP` and `o_stk_dat` = 0.
- **Accept:** `o_stk_vld & i_stk_rdy`. On accept:
  - `o_cmd_ack[winner]` = 1.
  - `rr_ptr` <= (winner+1) mod `ENGS_N`.
  - If the opcode is `OP_POP`, the winner's index is pushed into the tag FIFO.
- **Stall:** without accept, `rr_ptr` holds and no ack is given. The winner may change next cycle as requests change.
- **Response:** on `i_stk_rsp_vld`, pop the tag FIFO head h. Next cycle, `o_rsp_vld` = one-hot(h) and `o_rsp_dat` = `i_stk_rsp_dat`.
- **Response with empty FIFO:** `o_err` <= 1, `o_rsp_vld` stays 0, and FIFO pointers are unchanged.
- **Simultaneous push and pop of the tag FIFO:** occupancy unchanged; both pointers advance.
- **Pointers:** wrap modulo `TAG_DEPTH`. They are `log2(TAG_DEPTH)+1` bits wide, and full/empty is distinguished by the MSB.
- **Reset (async assert, any time):**
  - `rr_ptr` = 0, tag FIFO empty, `o_err` = 0.
  - `o_rsp_vld` = 0, `o_rsp_dat` = 0.
  - Combinational outputs follow inputs; with all `OP_NOP`, `o_stk_vld` = 0 and `o_cmd_ack` = 0.
  - Outstanding POPs are discarded. Responses arriving after reset set `o_err`.

## Timing
- **Command path:** combinational, zero latency. `o_stk_*` and `o_cmd_ack` depend on the cycle's requests, registered state and `i_stk_rdy`.
- **Response path:** `o_rsp_vld`/`o_rsp_dat` are registered, one cycle after `i_stk_rsp_vld`. One response per cycle is sustained.
- **Throughput:** one command per cycle. A requester held continuously is served at least once every `ENGS_N` accepts.
- **Response ordering:** the FIFO head is consumed before a same-cycle accepted POP is enqueued. A POP accepted at cycle t can therefore be answered at t+1 or later, never at t.

## Structure
- `stk_pkg` owns `opcode_t` (`OP_NOP`, `OP_PUSH`, `OP_POP`) and a `tag_t` typedef of width `$clog2(ENGS_N)`.
- `cfg_pkg` owns `ENGS_N`.
- One sub-module: `stk_tag_fifo`, a parameterised flop-based FIFO of `tag_t` with push, pop, full, empty and head outputs.
- The round-robin search stays inline.

## Test plan
- **Reset:** all requesters `OP_NOP`; assert `arst_n` = 0 mid-cycle → all outputs 0, `o_stk_opcode` = `OP_NOP`.
- **Round-robin:** requesters 0..3 all PUSH with data 0x10..0x13, `i_stk_rdy` = 1 → acks in order 0,1,2,3 on consecutive cycles; `o_stk_dat` sequence 0x10..0x13.
- **Backpressure:** requesters 1 and 2 PUSH, `i_stk_rdy` = 0 for 3 cycles → no acks and `rr_ptr` stays 0. `rdy` = 1 → ack 1, then ack 2.
- **POP routing:** POPs accepted from 2, 0, 3; stack responds 0xA, 0xB, 0xC on consecutive cycles → `o_rsp_vld` = 0100, 0001, 1000 each one cycle later, with `o_rsp_dat` 0xA, 0xB, 0xC.
- **Tag full:** 4 POPs outstanding (`TAG_DEPTH` = 4), requester 1 POP and requester 2 PUSH → requester 2 acked, requester 1 held. Requester 1 is acked the cycle after the first response.
- **Spurious response:** `i_stk_rsp_vld` with empty FIFO → `o_err` = 1 next cycle and remains set until reset; `o_rsp_vld` = 0.

Source files
------------

// File: rtl/cfg_pkg.sv
// System-level configuration shared by the stack command arbiter.
package cfg_pkg;
  localparam int unsigned ENGS_N = 4;
endpackage

// File: rtl/stk_pkg.sv
// Stack command types: opcode encoding and requester tag.
package stk_pkg;
  localparam int unsigned TagW = (cfg_pkg::ENGS_N > 1) ? $clog2(cfg_pkg::ENGS_N) : 1;

  typedef enum logic [1:0] {
    OP_NOP  = 2'd0,
    OP_PUSH = 2'd1,
    OP_POP  = 2'd2
  } opcode_t;

  typedef logic [TagW-1:0] tag_t;
endpackage

// File: rtl/stk_tag_fifo.sv
// In-order FIFO of requester tags for outstanding POPs; Depth must be a power of two >= 2.
module stk_tag_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned TagW  = $bits(stk_pkg::tag_t)
) (
  input  logic            clk,
  input  logic            arst_n,
  input  logic            push_i,
  input  logic [TagW-1:0] push_tag_i,
  input  logic            pop_i,
  output logic            full_o,
  output logic            empty_o,
  output logic [TagW-1:0] head_o
);
  localparam int unsigned AddrW = $clog2(Depth);

  // Extra MSB on each pointer separates full from empty when the addresses match.
  logic [AddrW:0]    wr_ptr_q, rd_ptr_q;
  logic [TagW-1:0]   mem_q [Depth];
  logic              do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                   (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign head_o  = mem_q[rd_ptr_q[AddrW-1:0]];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AddrW-1:0]] <= push_tag_i;
  end
endmodule

// File: rtl/stk_cmd_arb.sv
// Round-robin arbiter sharing one stack command port; routes POP responses back to their issuer.
module stk_cmd_arb
  import stk_pkg::*;
#(
  parameter int unsigned ENGS_N    = cfg_pkg::ENGS_N,
  parameter int unsigned W         = 128,
  parameter int unsigned TAG_DEPTH = 4
) (
  input  logic              clk,
  input  logic              arst_n,
  input  opcode_t           i_cmd_opcode [ENGS_N],
  input  logic [W-1:0]      i_cmd_dat    [ENGS_N],
  output logic [ENGS_N-1:0] o_cmd_ack,
  output logic              o_stk_vld,
  output opcode_t           o_stk_opcode,
  output logic [W-1:0]      o_stk_dat,
  input  logic              i_stk_rdy,
  input  logic              i_stk_rsp_vld,
  input  logic [W-1:0]      i_stk_rsp_dat,
  output logic [ENGS_N-1:0] o_rsp_vld,
  output logic [W-1:0]      o_rsp_dat,
  output logic              o_err
);
  localparam int unsigned IdxW = (ENGS_N > 1) ? $clog2(ENGS_N) : 1;

  logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d, winner, tag_head;
  logic [ENGS_N-1:0] eligible, rsp_vld_q;
  logic [W-1:0]      rsp_dat_q;
  logic              found, accept, tag_full, tag_empty, tag_push, tag_pop, err_q;
  int unsigned       idx;

  // POPs are held off while every tag slot is in use (registered occupancy only).
  always_comb begin
    for (int unsigned r = 0; r < ENGS_N; r++) begin
      eligible[r] = (i_cmd_opcode[r] != OP_NOP) && !((i_cmd_opcode[r] == OP_POP) && tag_full);
    end
  end

  always_comb begin
    found  = 1'b0;
    winner = rr_ptr_q;
    idx    = 0;
    for (int unsigned k = 0; k < ENGS_N; k++) begin
      idx = (32'(rr_ptr_q) + k) % ENGS_N;
      if (!found && eligible[idx]) begin
        found  = 1'b1;
        winner = idx[IdxW-1:0];
      end
    end
  end

  always_comb begin
    o_stk_vld    = found;
    o_stk_opcode = found ? i_cmd_opcode[winner] : OP_NOP;
    o_stk_dat    = found ? i_cmd_dat[winner] : '0;
    accept       = found & i_stk_rdy;
    o_cmd_ack    = accept ? (ENGS_N'(1) << winner) : '0;
    rr_ptr_d     = accept ? IdxW'((32'(winner) + 32'd1) % ENGS_N) : rr_ptr_q;
    tag_push     = accept && (o_stk_opcode == OP_POP);
    tag_pop      = i_stk_rsp_vld && !tag_empty;
  end

  stk_tag_fifo #(
    .Depth (TAG_DEPTH),
    .TagW  (IdxW)
  ) u_tag_fifo (
    .clk        (clk),
    .arst_n     (arst_n),
    .push_i     (tag_push),
    .push_tag_i (winner),
    .pop_i      (tag_pop),
    .full_o     (tag_full),
    .empty_o    (tag_empty),
    .head_o     (tag_head)
  );

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rr_ptr_q  <= '0;
      rsp_vld_q <= '0;
      rsp_dat_q <= '0;
      err_q     <= 1'b0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      rsp_vld_q <= tag_pop ? (ENGS_N'(1) << tag_head) : '0;
      if (tag_pop) rsp_dat_q <= i_stk_rsp_dat;
      if (i_stk_rsp_vld && tag_empty) err_q <= 1'b1;
    end
  end

  assign o_rsp_vld = rsp_vld_q;
  assign o_rsp_dat = rsp_dat_q;
  assign o_err     = err_q;
endmodule

// File: tb/tb_stk_cmd_arb.sv
// Directed and randomized checks of stk_cmd_arb against a queue-based reference model.
module tb_stk_cmd_arb;
  import stk_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 128;
  localparam int unsigned TD = 4;

  logic           clk, arst_n;
  opcode_t        cmd_op  [N];
  logic [W-1:0]   cmd_dat [N];
  logic [N-1:0]   cmd_ack, rsp_vld_o;
  logic           stk_vld, stk_rdy, rsp_vld, err;
  opcode_t        stk_op;
  logic [W-1:0]   stk_dat, rsp_dat, rsp_dat_o;

  int checks = 0;
  int failures = 0;

  stk_cmd_arb #(
    .ENGS_N    (N),
    .W         (W),
    .TAG_DEPTH (TD)
  ) dut (
    .clk           (clk),
    .arst_n        (arst_n),
    .i_cmd_opcode  (cmd_op),
    .i_cmd_dat     (cmd_dat),
    .o_cmd_ack     (cmd_ack),
    .o_stk_vld     (stk_vld),
    .o_stk_opcode  (stk_op),
    .o_stk_dat     (stk_dat),
    .i_stk_rdy     (stk_rdy),
    .i_stk_rsp_vld (rsp_vld),
    .i_stk_rsp_dat (rsp_dat),
    .o_rsp_vld     (rsp_vld_o),
    .o_rsp_dat     (rsp_dat_o),
    .o_err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge; outputs are sampled 3 units later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic all_nop();
    for (int r = 0; r < N; r++) begin
      cmd_op[r]  = OP_NOP;
      cmd_dat[r] = '0;
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_vld"}, W'(stk_vld), W'(0));
    check({tag, "_op"}, W'(stk_op), W'(OP_NOP));
    check({tag, "_dat"}, stk_dat, W'(0));
    check({tag, "_ack"}, W'(cmd_ack), W'(0));
    check({tag, "_rspvld"}, W'(rsp_vld_o), W'(0));
    check({tag, "_rspdat"}, rsp_dat_o, W'(0));
    check({tag, "_err"}, W'(err), W'(0));
  endtask

  // Reference model state
  int          m_rr;
  int          mq[$];
  logic        m_err;
  logic [N-1:0] m_rsp_vld;
  logic [W-1:0] m_rsp_dat;
  logic [3:0]  drain_exp [4];

  initial begin
    int     m_win, h;
    logic   m_found, m_full, accepted;

    arst_n = 1'b0; stk_rdy = 1'b0; rsp_vld = 1'b0; rsp_dat = '0;
    all_nop();
    #3;
    check_idle("reset");
    tick(); tick();
    arst_n = 1'b1;

    // Round-robin over four pushing requesters
    for (int r = 0; r < N; r++) begin
      cmd_op[r]  = OP_PUSH;
      cmd_dat[r] = W'(32'h10 + r);
    end
    stk_rdy = 1'b1;
    for (int c = 0; c < N; c++) begin
      #3;
      check("rr_ack", W'(cmd_ack), W'(4'b1 << c));
      check("rr_dat", stk_dat, W'(32'h10 + c));
      check("rr_op", W'(stk_op), W'(OP_PUSH));
      tick();
      cmd_op[c] = OP_NOP;
    end

    // Backpressure: no acks while not ready, order resumes from the same pointer
    cmd_op[1] = OP_PUSH; cmd_dat[1] = W'(32'h21);
    cmd_op[2] = OP_PUSH; cmd_dat[2] = W'(32'h22);
    stk_rdy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #3;
      check("bp_ack", W'(cmd_ack), W'(0));
      check("bp_vld", W'(stk_vld), W'(1));
      tick();
    end
    stk_rdy = 1'b1;
    #3;
    check("bp_ack1", W'(cmd_ack), W'(4'b0010));
    check("bp_dat1", stk_dat, W'(32'h21));
    tick(); cmd_op[1] = OP_NOP;
    #3;
    check("bp_ack2", W'(cmd_ack), W'(4'b0100));
    tick(); cmd_op[2] = OP_NOP;

    // POP routing: issue from 2, 0, 3 then answer in order
    cmd_op[2] = OP_POP; #3; check("pop_ack2", W'(cmd_ack), W'(4'b0100)); tick(); cmd_op[2] = OP_NOP;
    cmd_op[0] = OP_POP; #3; check("pop_ack0", W'(cmd_ack), W'(4'b0001)); tick(); cmd_op[0] = OP_NOP;
    cmd_op[3] = OP_POP; #3; check("pop_ack3", W'(cmd_ack), W'(4'b1000)); tick(); cmd_op[3] = OP_NOP;
    rsp_vld = 1'b1; rsp_dat = W'(32'hA); tick();
    rsp_dat = W'(32'hB); #3;
    check("route_vld_a", W'(rsp_vld_o), W'(4'b0100));
    check("route_dat_a", rsp_dat_o, W'(32'hA));
    tick();
    rsp_dat = W'(32'hC); #3;
    check("route_vld_b", W'(rsp_vld_o), W'(4'b0001));
    check("route_dat_b", rsp_dat_o, W'(32'hB));
    tick();
    rsp_vld = 1'b0; #3;
    check("route_vld_c", W'(rsp_vld_o), W'(4'b1000));
    check("route_dat_c", rsp_dat_o, W'(32'hC));
    tick(); #3;
    check("route_idle", W'(rsp_vld_o), W'(0));
    check("route_err", W'(err), W'(0));

    // Tag full: four POPs from requester 0 fill the FIFO
    tick();
    cmd_op[0] = OP_POP;
    for (int c = 0; c < TD; c++) begin
      #3; check("fill_ack", W'(cmd_ack), W'(4'b0001)); tick();
    end
    cmd_op[0] = OP_NOP;
    cmd_op[1] = OP_POP;
    cmd_op[2] = OP_PUSH; cmd_dat[2] = W'(32'h22);
    #3;
    check("full_ack_push", W'(cmd_ack), W'(4'b0100));
    check("full_op", W'(stk_op), W'(OP_PUSH));
    tick(); cmd_op[2] = OP_NOP;
    rsp_vld = 1'b1; rsp_dat = W'(32'h55);
    #3;
    check("full_hold_vld", W'(stk_vld), W'(0));
    check("full_hold_ack", W'(cmd_ack), W'(0));
    tick(); rsp_vld = 1'b0; #3;
    check("full_free_ack", W'(cmd_ack), W'(4'b0010));
    check("full_rsp_vld", W'(rsp_vld_o), W'(4'b0001));
    check("full_rsp_dat", rsp_dat_o, W'(32'h55));
    tick(); cmd_op[1] = OP_NOP;
    drain_exp[0] = 4'b0001; drain_exp[1] = 4'b0001; drain_exp[2] = 4'b0001;
    drain_exp[3] = 4'b0010;
    rsp_vld = 1'b1;
    for (int c = 0; c < 4; c++) begin
      rsp_dat = W'(32'h60 + c);
      tick();
      #3;
      check("drain_vld", W'(rsp_vld_o), W'(drain_exp[c]));
      check("drain_dat", rsp_dat_o, W'(32'h60 + c));
    end
    rsp_vld = 1'b0;

    // Spurious response with an empty FIFO
    tick();
    rsp_vld = 1'b1; rsp_dat = W'(32'h77);
    tick(); rsp_vld = 1'b0; #3;
    check("spur_err", W'(err), W'(1));
    check("spur_vld", W'(rsp_vld_o), W'(0));
    tick(); tick(); #3;
    check("spur_sticky", W'(err), W'(1));

    // Mid-cycle asynchronous reset clears everything
    tick(); #1;
    arst_n = 1'b0;
    #2;
    check_idle("midreset");
    tick();
    arst_n = 1'b1;

    // Randomized traffic against the reference model
    m_rr = 0; mq.delete(); m_err = 1'b0; m_rsp_vld = '0; m_rsp_dat = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int r = 0; r < N; r++) begin
        if (cmd_op[r] == OP_NOP && $urandom_range(0, 2) != 0) begin
          cmd_op[r]  = ($urandom_range(0, 1) == 0) ? OP_PUSH : OP_POP;
          cmd_dat[r] = {$urandom, $urandom, $urandom, $urandom};
        end
      end
      stk_rdy = ($urandom_range(0, 3) != 0);
      if (mq.size() > 0) rsp_vld = ($urandom_range(0, 1) == 1);
      else rsp_vld = ($urandom_range(0, 59) == 0);
      rsp_dat = {$urandom, $urandom, $urandom, $urandom};
      #3;

      m_full = (mq.size() >= TD);
      m_found = 1'b0; m_win = 0;
      for (int k = 0; k < N; k++) begin
        int r;
        r = (m_rr + k) % N;
        if (!m_found && cmd_op[r] != OP_NOP && !(cmd_op[r] == OP_POP && m_full)) begin
          m_found = 1'b1;
          m_win = r;
        end
      end
      accepted = m_found && stk_rdy;
      check("rnd_vld", W'(stk_vld), W'(m_found));
      check("rnd_op", W'(stk_op), m_found ? W'(cmd_op[m_win]) : W'(OP_NOP));
      check("rnd_dat", stk_dat, m_found ? cmd_dat[m_win] : W'(0));
      check("rnd_ack", W'(cmd_ack), accepted ? W'(4'b1 << m_win) : W'(0));
      check("rnd_rspvld", W'(rsp_vld_o), W'(m_rsp_vld));
      if (m_rsp_vld != 0) check("rnd_rspdat", rsp_dat_o, m_rsp_dat);
      check("rnd_err", W'(err), W'(m_err));

      // Response consumes the existing head before this cycle's POP is queued.
      m_rsp_vld = '0;
      if (rsp_vld) begin
        if (mq.size() > 0) begin
          h = mq.pop_front();
          m_rsp_vld = N'(1) << h;
          m_rsp_dat = rsp_dat;
        end else begin
          m_err = 1'b1;
        end
      end
      if (accepted) begin
        m_rr = (m_win + 1) % N;
        if (cmd_op[m_win] == OP_POP) mq.push_back(m_win);
      end
      tick();
      if (accepted) cmd_op[m_win] = OP_NOP;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
